vga_timing_recovery: RTL and testbench

- Receiver end of the team's 1024x768@60 VGA timing interface, fed by the 65 MHz pixel clock.
- Samples the hsync/vsync/hblnk/vblnk stream produced by the timing generator (or any upstream stage) and rebuilds hcount/vcount from it.
- Checks the stream against the package timing constants and reports lock and errors.
- Used after stage boundaries to re-derive coordinates and as a self-check monitor in game display pipelines.

---
 rtl/vga_timing_recovery.sv | 160 ++++++++++++++++
 tb/tb_vga_timing_recovery.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_recovery.sv
// Rebuilds hcount/vcount from a sampled hsync/vsync/hblnk/vblnk stream, acquires lock
// on the stream and reports sync/blank mismatches against the expected timing.
module vga_timing_recovery #(
  parameter int H_TOT        = 1344,
  parameter int H_BLNK_START = 1024,
  parameter int H_SYNC_START = 1048,
  parameter int H_SYNC_END   = 1184,
  parameter int V_TOT        = 806,
  parameter int V_BLNK_START = 768,
  parameter int V_SYNC_START = 771,
  parameter int V_SYNC_END   = 777,
  parameter int MISS_LIMIT   = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        hsync_in,
  input  logic        vsync_in,
  input  logic        hblnk_in,
  input  logic        vblnk_in,
  output logic [10:0] hcount_out,
  output logic [10:0] vcount_out,
  output logic        locked,
  output logic        frame_start,
  output logic        err_pulse,
  output logic [15:0] err_cnt
);

  // state     | meaning
  // ST_HUNT   | no alignment; vcount held at 0, waiting for any hsync rise
  // ST_H_ALIGN| hcount loaded once, waiting for a confirming hsync rise
  // ST_V_ALIGN| lines aligned, waiting for vsync rise at hcount 0
  // ST_LOCKED | tracking; sync events and blanking are checked every pixel
  typedef enum logic [1:0] {ST_HUNT, ST_H_ALIGN, ST_V_ALIGN, ST_LOCKED} state_t;

  localparam logic [10:0] HTOT_M1 = 11'(H_TOT - 1);
  localparam logic [10:0] VTOT_M1 = 11'(V_TOT - 1);
  localparam logic [10:0] HBS     = 11'(H_BLNK_START);
  localparam logic [10:0] HSS     = 11'(H_SYNC_START);
  localparam logic [10:0] HSE     = 11'(H_SYNC_END);
  localparam logic [10:0] VBS     = 11'(V_BLNK_START);
  localparam logic [10:0] VSS     = 11'(V_SYNC_START);
  localparam logic [10:0] VSE     = 11'(V_SYNC_END);
  localparam logic [2:0]  MISS_LIM = 3'(MISS_LIMIT);

  state_t      state_q, state_d;
  logic [2:0]  miss_q, miss_d;
  logic [10:0] h_q, h_d, v_q, v_d;
  logic        hs_q, vs_q;
  logic [10:0] hcount_q, vcount_q;
  logic        locked_q, frame_start_q, err_pulse_q;
  logic [15:0] err_cnt_q;

  logic [10:0] cur_h, cur_v;
  logic        h_rise, h_fall, v_rise, v_fall, sync_ev, sync_bad, blank_bad, err;

  // The counters name the pixel currently on the pins; the sync registers hold the
  // previous pixel, so an edge is known in the same cycle as the pixel that carries it.
  always_comb begin
    state_d   = state_q;
    miss_d    = miss_q;
    cur_h     = h_q;
    cur_v     = v_q;
    err       = 1'b0;
    h_rise    = hsync_in & ~hs_q;
    h_fall    = ~hsync_in & hs_q;
    v_rise    = vsync_in & ~vs_q;
    v_fall    = ~vsync_in & vs_q;
    sync_ev   = h_rise | h_fall | v_rise | v_fall;
    sync_bad  = (h_rise && (h_q != HSS)) ||
                (h_fall && (h_q != HSE)) ||
                (v_rise && !((h_q == 11'd0) && (v_q == VSS))) ||
                (v_fall && !((h_q == 11'd0) && (v_q == VSE)));
    blank_bad = (hblnk_in != (h_q >= HBS)) || (vblnk_in != (v_q >= VBS));

    case (state_q)
      ST_HUNT: begin
        cur_v = 11'd0;
        if (h_rise) begin
          cur_h   = HSS;
          state_d = ST_H_ALIGN;
        end
      end
      ST_H_ALIGN: begin
        if (h_rise) begin
          if (h_q == HSS) state_d = ST_V_ALIGN;
          else            cur_h   = HSS;
        end
      end
      ST_V_ALIGN: begin
        if (h_rise && (h_q != HSS)) begin
          cur_h   = HSS;
          state_d = ST_H_ALIGN;
        end else if (v_rise && (h_q == 11'd0)) begin
          cur_v   = VSS;
          state_d = ST_LOCKED;
        end
      end
      default: begin
        err = blank_bad | (sync_ev & sync_bad);
        if (sync_ev) begin
          if (sync_bad) begin
            miss_d = miss_q + 3'd1;
            if (miss_d >= MISS_LIM) begin
              miss_d  = 3'd0;
              state_d = ST_HUNT;
            end
          end else begin
            miss_d = 3'd0;
          end
        end
      end
    endcase

    if (cur_h == HTOT_M1) begin
      h_d = 11'd0;
      v_d = (cur_v == VTOT_M1) ? 11'd0 : cur_v + 11'd1;
    end else begin
      h_d = cur_h + 11'd1;
      v_d = cur_v;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_HUNT;
      miss_q        <= 3'd0;
      h_q           <= 11'd0;
      v_q           <= 11'd0;
      hs_q          <= 1'b0;
      vs_q          <= 1'b0;
      hcount_q      <= 11'd0;
      vcount_q      <= 11'd0;
      locked_q      <= 1'b0;
      frame_start_q <= 1'b0;
      err_pulse_q   <= 1'b0;
      err_cnt_q     <= 16'd0;
    end else begin
      state_q       <= state_d;
      miss_q        <= miss_d;
      h_q           <= h_d;
      v_q           <= v_d;
      hs_q          <= hsync_in;
      vs_q          <= vsync_in;
      hcount_q      <= cur_h;
      vcount_q      <= cur_v;
      locked_q      <= (state_d == ST_LOCKED);
      frame_start_q <= (state_d == ST_LOCKED) && (cur_h == 11'd0) && (cur_v == 11'd0);
      err_pulse_q   <= err;
      if (err && (err_cnt_q != 16'hFFFF)) err_cnt_q <= err_cnt_q + 16'd1;
    end
  end

  assign hcount_out  = hcount_q;
  assign vcount_out  = vcount_q;
  assign locked      = locked_q;
  assign frame_start = frame_start_q;
  assign err_pulse   = err_pulse_q;
  assign err_cnt     = err_cnt_q;

endmodule

// File: tb/tb_vga_timing_recovery.sv
// Scoreboarded bench for vga_timing_recovery on a shrunken raster: a generator with
// random line perturbations feeds the DUT and a position-based reference model.
module tb_vga_timing_recovery;

  localparam int H_TOT = 48, HBS = 32, HSS = 34, HSE = 42;
  localparam int V_TOT = 20, VBS = 14, VSS = 15, VSE = 17;
  localparam int ML = 2;
  localparam int FRAME = H_TOT * V_TOT;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic        hsync_in = 1'b0, vsync_in = 1'b0, hblnk_in = 1'b0, vblnk_in = 1'b0;
  logic [10:0] hcount_out, vcount_out;
  logic        locked, frame_start, err_pulse;
  logic [15:0] err_cnt;

  always #5 clk = ~clk;

  vga_timing_recovery #(
    .H_TOT(H_TOT), .H_BLNK_START(HBS), .H_SYNC_START(HSS), .H_SYNC_END(HSE),
    .V_TOT(V_TOT), .V_BLNK_START(VBS), .V_SYNC_START(VSS), .V_SYNC_END(VSE),
    .MISS_LIMIT(ML)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .hsync_in(hsync_in), .vsync_in(vsync_in), .hblnk_in(hblnk_in), .vblnk_in(vblnk_in),
    .hcount_out(hcount_out), .vcount_out(vcount_out), .locked(locked),
    .frame_start(frame_start), .err_pulse(err_pulse), .err_cnt(err_cnt)
  );

  typedef struct {
    int hc; int vc; bit lk; bit fs; bit ep; int ec;
  } exp_t;

  exp_t sbq[$];
  int   n_checks = 0, n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
    end
  endtask

  // Reference model: a linear raster position plus acquisition level
  // (0 searching, 1 line loaded, 2 line confirmed, 3 locked).
  int m_pos, m_acq, m_miss, m_ecnt;
  bit m_phs, m_pvs;

  task automatic model_reset();
    m_pos = 0; m_acq = 0; m_miss = 0; m_ecnt = 0; m_phs = 0; m_pvs = 0;
  endtask

  function automatic bit ideal_hs(int p);
    return ((p % H_TOT) >= HSS) && ((p % H_TOT) < HSE);
  endfunction

  function automatic bit ideal_vs(int p);
    return ((p / H_TOT) >= VSS) && ((p / H_TOT) < VSE);
  endfunction

  function automatic int prevp(int p);
    return (p + FRAME - 1) % FRAME;
  endfunction

  task automatic model_step(input bit hs, input bit vs, input bit hb, input bit vb, output exp_t e);
    bit hr, hf, vr, vf, ev, bad, err, was_locked;
    hr = hs && !m_phs; hf = !hs && m_phs;
    vr = vs && !m_pvs; vf = !vs && m_pvs;
    was_locked = (m_acq == 3);
    err = 0;
    if (m_acq == 0) m_pos = m_pos % H_TOT;
    case (m_acq)
      0: if (hr) begin m_pos = HSS; m_acq = 1; end
      1: if (hr) begin
           if (m_pos % H_TOT == HSS) m_acq = 2;
           else m_pos = (m_pos / H_TOT) * H_TOT + HSS;
         end
      2: if (hr && (m_pos % H_TOT != HSS)) begin
           m_pos = (m_pos / H_TOT) * H_TOT + HSS; m_acq = 1;
         end else if (vr && (m_pos % H_TOT == 0)) begin
           m_pos = VSS * H_TOT; m_acq = 3;
         end
      default: begin
        ev  = hr || hf || vr || vf;
        bad = (hr && !( ideal_hs(m_pos) && !ideal_hs(prevp(m_pos)))) ||
              (hf && !(!ideal_hs(m_pos) &&  ideal_hs(prevp(m_pos)))) ||
              (vr && !( ideal_vs(m_pos) && !ideal_vs(prevp(m_pos)))) ||
              (vf && !(!ideal_vs(m_pos) &&  ideal_vs(prevp(m_pos))));
        err = (ev && bad) || (hb != ((m_pos % H_TOT) >= HBS)) || (vb != ((m_pos / H_TOT) >= VBS));
        if (ev) m_miss = bad ? m_miss + 1 : 0;
        if (m_miss >= ML) begin m_miss = 0; m_acq = 0; end
      end
    endcase
    e.hc = m_pos % H_TOT;
    e.vc = m_pos / H_TOT;
    e.lk = (m_acq == 3);
    e.fs = e.lk && (m_pos == 0);
    e.ep = was_locked && err;
    if (e.ep && m_ecnt < 65535) m_ecnt++;
    e.ec = m_ecnt;
    m_pos = (m_pos + 1) % FRAME;
    m_phs = hs; m_pvs = vs;
  endtask

  // Monitor: outputs for a pixel are visible one clock after it was driven.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sbq.size() >= 2) begin
        e = sbq.pop_front();
        chk("hcount_out",  32'(hcount_out),  e.hc);
        chk("vcount_out",  32'(vcount_out),  e.vc);
        chk("locked",      32'(locked),      32'(e.lk));
        chk("frame_start", 32'(frame_start), 32'(e.fs));
        chk("err_pulse",   32'(err_pulse),   32'(e.ep));
        chk("err_cnt",     32'(err_cnt),     e.ec);
      end
    end
  end

  // Generator position and per-line perturbations (cleared at each line wrap).
  int g_h = 0, g_v = 0;
  int r_shift = 0, p_shift = 0, hg_s = 0, hg_l = 0, vg_s = 0, vg_l = 0;

  task automatic drive(input bit hs, input bit vs, input bit hb, input bit vb);
    exp_t e;
    hsync_in = hs; vsync_in = vs; hblnk_in = hb; vblnk_in = vb;
    model_step(hs, vs, hb, vb, e);
    sbq.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic gen_pixel();
    bit hs, vs, hb, vb;
    hs = (g_h >= HSS + p_shift + r_shift) && (g_h < HSE + p_shift);
    vs = (g_v >= VSS) && (g_v < VSE);
    hb = (g_h >= HBS) ^ ((g_h >= hg_s) && (g_h < hg_s + hg_l));
    vb = (g_v >= VBS) ^ ((g_h >= vg_s) && (g_h < vg_s + vg_l));
    drive(hs, vs, hb, vb);
    g_h++;
    if (g_h == H_TOT) begin
      g_h = 0; g_v = (g_v + 1) % V_TOT;
      r_shift = 0; p_shift = 0; hg_l = 0; vg_l = 0;
    end
  endtask

  task automatic to_line_start();
    while (g_h != 0) gen_pixel();
  endtask

  task automatic run_line();
    for (int i = 0; i < H_TOT; i++) gen_pixel();
  endtask

  task automatic wait_lock(input string name, input int budget, output int used);
    used = 0;
    while (!locked && used < budget) begin gen_pixel(); used++; end
    chk(name, 32'(locked), 1);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_hcount"}, 32'(hcount_out), 0);
    chk({tag, "_vcount"}, 32'(vcount_out), 0);
    chk({tag, "_locked"}, 32'(locked), 0);
    chk({tag, "_fstart"}, 32'(frame_start), 0);
    chk({tag, "_errp"},   32'(err_pulse), 0);
    chk({tag, "_errcnt"}, 32'(err_cnt), 0);
  endtask

  initial begin
    int used, last, nfs, nerr, base, r;
    bit seen;
    model_reset();
    #3;
    check_all_zero("reset");
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Acquisition from a clean stream starting at the raster origin
    wait_lock("initial_lock", 3 * FRAME, used);
    chk("lock_hcount", 32'(hcount_out), 0);
    chk("lock_vcount", 32'(vcount_out), VSS);
    chk("lock_errcnt", 32'(err_cnt), 0);
    chk("lock_pixels", used, VSS * H_TOT + 1);

    // Three clean frames
    last = -1; nfs = 0; nerr = 0;
    for (int i = 0; i < 3 * FRAME; i++) begin
      gen_pixel();
      if (frame_start) begin
        if (last >= 0) chk("fs_interval", i - last, FRAME);
        last = i; nfs++;
      end
      if (err_pulse) nerr++;
    end
    chk("fs_count", nfs, 3);
    chk("clean_err_pulses", nerr, 0);

    // Single hsync rise late by 5 pixels
    to_line_start();
    base = int'(err_cnt);
    r_shift = 5;
    run_line();
    run_line();
    chk("shift_errcnt", 32'(err_cnt), base + 1);
    chk("shift_locked", 32'(locked), 1);

    // hblnk forced low for 10 pixels inside the blank region
    base = int'(err_cnt);
    hg_s = HBS + 1; hg_l = 10;
    run_line();
    chk("blank_errcnt", 32'(err_cnt), base + 10);
    chk("blank_locked", 32'(locked), 1);

    // Random line perturbations
    for (int l = 0; l < 40; l++) begin
      r = int'($urandom_range(0, 7));
      case (r)
        0: r_shift = int'($urandom_range(1, HSE - HSS - 1));
        1: begin hg_s = int'($urandom_range(0, H_TOT - 1)); hg_l = int'($urandom_range(1, 6)); end
        2: begin vg_s = int'($urandom_range(0, H_TOT - 1)); vg_l = int'($urandom_range(1, 6)); end
        3: p_shift = int'($urandom_range(1, 3));
        default: ;
      endcase
      run_line();
    end

    // Two consecutive badly placed hsync lines drop lock
    wait_lock("pre_double_lock", 3 * FRAME, used);
    to_line_start();
    base = int'(err_cnt);
    p_shift = 3;
    run_line();
    p_shift = 3;
    run_line();
    chk("double_errcnt", 32'(err_cnt), base + 2);
    chk("double_locked", 32'(locked), 0);
    wait_lock("relock", 3 * FRAME, used);

    // Asynchronous reset in the middle of a frame
    for (int i = 0; i < FRAME / 2 + 7; i++) gen_pixel();
    chk("pre_reset_locked", 32'(locked), 1);
    #2 rst_n = 1'b0;
    #1;
    check_all_zero("midreset");
    sbq.delete();
    model_reset();
    hsync_in = 1'b0; vsync_in = 1'b0; hblnk_in = 1'b0; vblnk_in = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    g_h = int'($urandom_range(0, H_TOT - 1));
    g_v = int'($urandom_range(1, V_TOT - 1));
    seen = 0;
    for (int i = 0; i < H_TOT; i++) begin
      gen_pixel();
      if (locked) seen = 1;
    end
    chk("post_reset_unlocked", 32'(seen), 0);
    wait_lock("post_reset_relock", 3 * FRAME, used);

    for (int i = 0; i < H_TOT; i++) gen_pixel();
    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
